mem_region_router: RTL
======================

MEM_REGION_ROUTER -- requirements
Module: mem_region_router

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_REGIONS, 3, number of decoded target regions (1..8).
- REGION_BASE, {32'h8001_0000, 32'h8000_0000, 32'h0000_0000}, flat NUM_REGIONS*32 bases, region r at bits [32r+31:32r].
- REGION_MASK, {32'hFFFF_F000, 32'hFFFF_8000, 32'h8000_0000}, flat NUM_REGIONS*32 match masks.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before an error response (1..65535).
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is rising-edge clocked.
- rst, in, 1, reset, asynchronous and active-high.
- For port X in {A, B}, upstream side:
  - isRequestX, in, 1, request.
  - weX, in, 4, byte write enables; 0 means read.
  - addrX, in, 32, address.
  - dinX, in, 32, write data.
  - doutX, out, 32, read data.
  - requestDoneX, out, 1, one-cycle completion pulse.
  - readValidX, out, 1, doutX valid; coincides with requestDoneX.
  - errorX, out, 1, error flag; coincides with requestDoneX.
- For port X, region side:
  - regReqX, out, NUM_REGIONS, one-hot request.
  - regAddrX, out, 32, held address.
  - regDinX, out, 32, held write data.
  - regWeX, out, 4, held byte enables.
  - regDoutX, in, NUM_REGIONS*32, per-region read data.
  - regDoneX, in, NUM_REGIONS, per-region done.
  - regValidX, in, NUM_REGIONS, per-region read-valid.

Function
REQ-003 Ports A and B SHALL be fully independent, identical channels; no arbitration between them.
REQ-004 Region r SHALL match when (addr & MASK_r) == BASE_r; the lowest matching index wins; no match is a miss.
REQ-005 Each channel SHALL implement FSM states IDLE and BUSY.
REQ-006 In IDLE with isRequestX=1 and a hit on region r, the channel SHALL, at the clock edge:
- latch addr, din, we and the index r;
- set regReqX to one-hot r;
- clear the timeout counter;
- enter BUSY.
REQ-007 In IDLE with isRequestX=1 and a miss, the channel SHALL stay in IDLE and, in the next cycle, drive requestDoneX=1, errorX=1, readValidX=0 and doutX=0.
REQ-008 While in BUSY, the channel SHALL:
- hold regReqX, regAddrX, regDinX and regWeX constant;
- ignore isRequestX;
- sample only regDoneX[r], regValidX[r] and regDoutX[r] of the latched region; the other regions' inputs have no effect.
REQ-009 When regDoneX[r]=1 in BUSY, the channel SHALL, at that edge:
- clear regReqX and return to IDLE;
- register doutX from slice r when regValidX[r]=1, otherwise hold doutX at 0;
- in the following cycle, drive requestDoneX=1, readValidX=regValidX[r] and errorX=0.
REQ-010 The timeout counter SHALL increment each BUSY cycle without regDoneX[r]. When it reaches TIMEOUT_CYCLES, the channel SHALL clear regReqX and return to IDLE, then pulse requestDoneX=1 and errorX=1 with readValidX=0 and doutX=0.
REQ-011 A regDoneX arriving in IDLE, such as a late response after a timeout, SHALL be ignored.
REQ-012 requestDoneX, readValidX and errorX SHALL be registered outputs, high for exactly one cycle per request and 0 otherwise.
REQ-013 doutX SHALL hold its last value until the next completion.
REQ-014 A new request SHALL be accepted in IDLE in the same cycle that the previous requestDoneX pulse is high, giving back-to-back throughput.
REQ-015 Latency SHALL be:
- miss: requestDoneX 1 cycle after the request edge;
- hit with regDone in the first BUSY cycle: 2 cycles;
- hit in general: 1 cycle after the regDone edge.
REQ-016 The decoder output (the one-hot region select) SHALL be evaluated only in IDLE. Address changes during BUSY SHALL NOT alter routing.

Reset
REQ-017 Asserting rst SHALL immediately, without waiting for a clock edge:
- set both FSMs to IDLE;
- set regReqX and the timeout counters to 0;
- set requestDoneX, readValidX, errorX and doutX to 0;
- set regAddrX, regDinX and regWeX to 0.
REQ-018 Reset asserted mid-transaction SHALL abort that transaction with no requestDoneX pulse. After deassertion, the first rising edge SHALL accept a new request.

Verification
REQ-019 Directed bench scenarios (stimulus -> required response):
- Read on A at addrA=0x0000_0040; region 0 returns regDoneA[0]=1, regValidA[0]=1, data 0xDEAD_BEEF one cycle later -> regReqA=3'b001, then a requestDoneA/readValidA pulse with doutA=0xDEAD_BEEF, errorA=0, 2 cycles after the request.
- Write on B: weB=4'hF at addrB=0x8000_0010, dinB=0x1234_5678 -> regReqB=3'b010, regDinB=0x1234_5678; after regDoneB[1], requestDoneB=1 with readValidB=0.
- addrA=0x8002_0000 (miss) -> next cycle requestDoneA=1, errorA=1, doutA=0; regReqA stays 0.
- TIMEOUT_CYCLES=4, region never responds -> regReqA drops after 4 BUSY cycles; requestDoneA=1 and errorA=1; a late regDoneA is ignored.
- Simultaneous A read of region 2 (0x8001_0004) and B read of region 0, each with different done delays -> each port completes with its own region's data, unaffected by the other port.
- rst pulsed while A is BUSY -> regReqA=0 immediately, no requestDoneA pulse; a request on the first edge after reset is accepted.

Source files
------------

// File: rtl/mem_region_router.sv
// mem_region_channel: one independent request channel of the region router.
// Decodes the upstream address against the region table, forwards the
// request to the single matching region, and returns a registered one-cycle
// completion (requestDone/readValid/error, dout) to the requester.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   isRequest, we, addr, din      upstream request (we == 0 means read)
//   dout, requestDone,
//   readValid, error              upstream completion, registered
//   regReq, regAddr, regDin,
//   regWe                         region-side request, held while BUSY
//   regDout, regDone, regValid    per-region response inputs
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | decoder live; a hit launches a region request, a miss answers
//       | with an error on the next cycle
// BUSY  | request held on the latched region; waiting for its done or
//       | for the timeout counter to expire
module mem_region_channel #(
   parameter int                       NUM_REGIONS    = 3,
   parameter logic [NUM_REGIONS*32-1:0] REGION_BASE   = {32'h8001_0000, 32'h8000_0000, 32'h0000_0000},
   parameter logic [NUM_REGIONS*32-1:0] REGION_MASK   = {32'hFFFF_F000, 32'hFFFF_8000, 32'h8000_0000},
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      isRequest,
   input  logic [3:0]                we,
   input  logic [31:0]               addr,
   input  logic [31:0]               din,
   output logic [31:0]               dout,
   output logic                      requestDone,
   output logic                      readValid,
   output logic                      error,
   output logic [NUM_REGIONS-1:0]    regReq,
   output logic [31:0]               regAddr,
   output logic [31:0]               regDin,
   output logic [3:0]                regWe,
   input  logic [NUM_REGIONS*32-1:0] regDout,
   input  logic [NUM_REGIONS-1:0]    regDone,
   input  logic [NUM_REGIONS-1:0]    regValid
);

   localparam int IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int NUM_PAD = 1 << IDX_W;
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} stateT;

   stateT                  state, nextState;
   logic [IDX_W-1:0]       regIdx, regIdxNext;
   logic [15:0]            timer, timerNext;
   logic [NUM_REGIONS-1:0] regReqNext;
   logic [31:0]            regAddrNext, regDinNext, doutNext;
   logic [3:0]             regWeNext;
   logic                   requestDoneNext, readValidNext, errorNext;

   logic                   hit;
   logic [IDX_W-1:0]       hitIdx;

   // Response inputs padded to a power of two so the latched index can never
   // select past the end of the vector.
   logic [NUM_PAD-1:0]     donePad, validPad;
   logic [NUM_PAD*32-1:0]  doutPad;
   logic [31:0]            selDout;

   assign donePad  = NUM_PAD'(regDone);
   assign validPad = NUM_PAD'(regValid);
   assign doutPad  = (NUM_PAD*32)'(regDout);
   assign selDout  = doutPad[regIdx*32 +: 32];

   // Scan from the top down so the lowest matching region is the last writer.
   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if ((addr & REGION_MASK[r*32 +: 32]) == REGION_BASE[r*32 +: 32]) begin
            hit    = 1'b1;
            hitIdx = IDX_W'(r);
         end
      end
   end

   always_comb begin
      nextState       = state;
      regIdxNext      = regIdx;
      timerNext       = timer;
      regReqNext      = regReq;
      regAddrNext     = regAddr;
      regDinNext      = regDin;
      regWeNext       = regWe;
      doutNext        = dout;
      requestDoneNext = 1'b0;
      readValidNext   = 1'b0;
      errorNext       = 1'b0;
      case (state)
         IDLE: begin
            if (isRequest) begin
               if (hit) begin
                  nextState   = BUSY;
                  regIdxNext  = hitIdx;
                  regReqNext  = NUM_REGIONS'(1) << hitIdx;
                  regAddrNext = addr;
                  regDinNext  = din;
                  regWeNext   = we;
                  timerNext   = '0;
               end else begin
                  requestDoneNext = 1'b1;
                  errorNext       = 1'b1;
                  doutNext        = '0;
               end
            end
         end
         BUSY: begin
            // A done on the expiry cycle still counts as a normal completion.
            if (donePad[regIdx]) begin
               nextState       = IDLE;
               regReqNext      = '0;
               requestDoneNext = 1'b1;
               readValidNext   = validPad[regIdx];
               doutNext        = validPad[regIdx] ? selDout : '0;
            end else if (timer == TIMER_LAST) begin
               nextState       = IDLE;
               regReqNext      = '0;
               requestDoneNext = 1'b1;
               errorNext       = 1'b1;
               doutNext        = '0;
            end else begin
               timerNext = timer + 16'd1;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         regIdx      <= '0;
         timer       <= '0;
         regReq      <= '0;
         regAddr     <= '0;
         regDin      <= '0;
         regWe       <= '0;
         dout        <= '0;
         requestDone <= 1'b0;
         readValid   <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= nextState;
         regIdx      <= regIdxNext;
         timer       <= timerNext;
         regReq      <= regReqNext;
         regAddr     <= regAddrNext;
         regDin      <= regDinNext;
         regWe       <= regWeNext;
         dout        <= doutNext;
         requestDone <= requestDoneNext;
         readValid   <= readValidNext;
         error       <= errorNext;
      end
   end

endmodule

// mem_region_router: two fully independent channels (A and B) routing
// upstream requests to address-decoded target regions. No arbitration
// between the channels; each owns its own set of region-side signals.
//
// Ports (X in {A, B})
//   clk, rst                                  clock, async active-high reset
//   isRequestX, weX, addrX, dinX              upstream request
//   doutX, requestDoneX, readValidX, errorX   upstream completion
//   regReqX, regAddrX, regDinX, regWeX        region-side request
//   regDoutX, regDoneX, regValidX             region-side response
module mem_region_router #(
   parameter int                       NUM_REGIONS    = 3,
   parameter logic [NUM_REGIONS*32-1:0] REGION_BASE   = {32'h8001_0000, 32'h8000_0000, 32'h0000_0000},
   parameter logic [NUM_REGIONS*32-1:0] REGION_MASK   = {32'hFFFF_F000, 32'hFFFF_8000, 32'h8000_0000},
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      isRequestA,
   input  logic [3:0]                weA,
   input  logic [31:0]               addrA,
   input  logic [31:0]               dinA,
   output logic [31:0]               doutA,
   output logic                      requestDoneA,
   output logic                      readValidA,
   output logic                      errorA,
   output logic [NUM_REGIONS-1:0]    regReqA,
   output logic [31:0]               regAddrA,
   output logic [31:0]               regDinA,
   output logic [3:0]                regWeA,
   input  logic [NUM_REGIONS*32-1:0] regDoutA,
   input  logic [NUM_REGIONS-1:0]    regDoneA,
   input  logic [NUM_REGIONS-1:0]    regValidA,
   input  logic                      isRequestB,
   input  logic [3:0]                weB,
   input  logic [31:0]               addrB,
   input  logic [31:0]               dinB,
   output logic [31:0]               doutB,
   output logic                      requestDoneB,
   output logic                      readValidB,
   output logic                      errorB,
   output logic [NUM_REGIONS-1:0]    regReqB,
   output logic [31:0]               regAddrB,
   output logic [31:0]               regDinB,
   output logic [3:0]                regWeB,
   input  logic [NUM_REGIONS*32-1:0] regDoutB,
   input  logic [NUM_REGIONS-1:0]    regDoneB,
   input  logic [NUM_REGIONS-1:0]    regValidB
);

   mem_region_channel #(
      .NUM_REGIONS(NUM_REGIONS), .REGION_BASE(REGION_BASE),
      .REGION_MASK(REGION_MASK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) channelA (
      .clk(clk), .rst(rst),
      .isRequest(isRequestA), .we(weA), .addr(addrA), .din(dinA),
      .dout(doutA), .requestDone(requestDoneA), .readValid(readValidA), .error(errorA),
      .regReq(regReqA), .regAddr(regAddrA), .regDin(regDinA), .regWe(regWeA),
      .regDout(regDoutA), .regDone(regDoneA), .regValid(regValidA)
   );

   mem_region_channel #(
      .NUM_REGIONS(NUM_REGIONS), .REGION_BASE(REGION_BASE),
      .REGION_MASK(REGION_MASK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) channelB (
      .clk(clk), .rst(rst),
      .isRequest(isRequestB), .we(weB), .addr(addrB), .din(dinB),
      .dout(doutB), .requestDone(requestDoneB), .readValid(readValidB), .error(errorB),
      .regReq(regReqB), .regAddr(regAddrB), .regDin(regDinB), .regWe(regWeB),
      .regDout(regDoutB), .regDone(regDoneB), .regValid(regValidB)
   );

endmodule
